// File: rtl/pm_loader_pkg.sv
// Shared types and constants for the program-memory loader.
// PM_LOADER_CHECKSUM_EN adds the GET_SUM state to the FSM encoding.
package pm_loader_pkg;

    localparam int         PM_DEPTH  = 256;
    localparam logic [7:0] PM_SUM_OK = 8'h00;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_ADDR = 3'd1,
        GET_LEN  = 3'd2,
        GET_DATA = 3'd3,
`ifdef PM_LOADER_CHECKSUM_EN
        GET_SUM  = 3'd4,
`endif
        FINISH   = 3'd5
    } pm_ld_state_t;

endpackage

// File: rtl/pm_loader.sv
// Byte-stream loader for the MPU341 program memory.
// Frame: ADDR, LEN (count-1), LEN+1 data bytes; CPU held in reset during a load.
// Build option PM_LOADER_CHECKSUM_EN: trailing checksum byte, err on bad sum.
module pm_loader
    import pm_loader_pkg::*;
#(
    parameter int ADDR_W        = 8,
    parameter int DATA_W        = 8,
    parameter bit HOLD_AT_RESET = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              pm_we,
    output logic [ADDR_W-1:0] pm_addr,
    output logic [DATA_W-1:0] pm_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = $clog2(PM_DEPTH);

    pm_ld_state_t      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pm_we_q, pm_we_d;
    logic [ADDR_W-1:0] pm_addr_q, pm_addr_d;
    logic [DATA_W-1:0] pm_wdata_q, pm_wdata_d;
    logic              cpu_hold_q, cpu_hold_d;
`ifdef PM_LOADER_CHECKSUM_EN
    logic              err_q, err_d;
    logic [DATA_W-1:0] sum_q, sum_d;
`endif

    logic xfer;

    // Ready is a pure function of state so there is no s_valid -> s_ready path.
    always_comb begin
        s_ready = (state_q == GET_ADDR) || (state_q == GET_LEN) || (state_q == GET_DATA)
`ifdef PM_LOADER_CHECKSUM_EN
               || (state_q == GET_SUM)
`endif
               ;
    end

    assign xfer     = s_valid && s_ready;
    assign pm_we    = pm_we_q;
    assign pm_addr  = pm_addr_q;
    assign pm_wdata = pm_wdata_q;
    assign cpu_hold = cpu_hold_q;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == FINISH);
`ifdef PM_LOADER_CHECKSUM_EN
    assign err      = err_q;
`else
    assign err      = 1'b0;
`endif

    // Next-state, counters, registered write port and hold control.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        pm_we_d    = 1'b0;
        pm_addr_d  = pm_addr_q;
        pm_wdata_d = pm_wdata_q;
        cpu_hold_d = cpu_hold_q;
`ifdef PM_LOADER_CHECKSUM_EN
        err_d      = err_q;
        sum_d      = sum_q;
`endif
        case (state_q)
            IDLE: begin
                // a byte presented alongside start is left for GET_ADDR
                if (start) begin
                    cpu_hold_d = 1'b1;
`ifdef PM_LOADER_CHECKSUM_EN
                    err_d      = 1'b0;
                    sum_d      = '0;
`endif
                    state_d    = GET_ADDR;
                end
            end
            GET_ADDR: begin
                if (xfer) begin
                    addr_d  = ADDR_W'(s_data);
`ifdef PM_LOADER_CHECKSUM_EN
                    sum_d   = sum_q + s_data;
`endif
                    state_d = GET_LEN;
                end
            end
            GET_LEN: begin
                if (xfer) begin
                    cnt_d   = CNT_W'(s_data);
`ifdef PM_LOADER_CHECKSUM_EN
                    sum_d   = sum_q + s_data;
`endif
                    state_d = GET_DATA;
                end
            end
            GET_DATA: begin
                if (xfer) begin
                    pm_we_d    = 1'b1;
                    pm_addr_d  = addr_q;
                    pm_wdata_d = s_data;
                    addr_d     = addr_q + 1'b1;   // wraps 0xFF -> 0x00
                    cnt_d      = cnt_q - 1'b1;
`ifdef PM_LOADER_CHECKSUM_EN
                    sum_d      = sum_q + s_data;
                    if (cnt_q == '0) state_d = GET_SUM;
`else
                    if (cnt_q == '0) state_d = FINISH;
`endif
                end
            end
`ifdef PM_LOADER_CHECKSUM_EN
            GET_SUM: begin
                if (xfer) begin
                    err_d   = ((sum_q + s_data) != PM_SUM_OK);
                    state_d = FINISH;
                end
            end
`endif
            FINISH: begin
                // a failed checksum keeps the CPU parked in reset
`ifdef PM_LOADER_CHECKSUM_EN
                cpu_hold_d = err_q;
`else
                cpu_hold_d = 1'b0;
`endif
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any session in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            pm_we_q    <= 1'b0;
            pm_addr_q  <= '0;
            pm_wdata_q <= '0;
            cpu_hold_q <= HOLD_AT_RESET;
`ifdef PM_LOADER_CHECKSUM_EN
            err_q      <= 1'b0;
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            pm_we_q    <= pm_we_d;
            pm_addr_q  <= pm_addr_d;
            pm_wdata_q <= pm_wdata_d;
            cpu_hold_q <= cpu_hold_d;
`ifdef PM_LOADER_CHECKSUM_EN
            err_q      <= err_d;
            sum_q      <= sum_d;
`endif
        end
    end

endmodule

// File: tb/tb_pm_loader.sv
// Directed bench for pm_loader: reset, basic load, start+byte, wrap/max length,
// backpressure with stray start, mid-load reset, checksum (when built with it).
module tb_pm_loader;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       start;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic       pm_we;
    logic [7:0] pm_addr;
    logic [7:0] pm_wdata;
    logic       cpu_hold;
    logic       busy;
    logic       done;
    logic       err;

    always #5 clock = ~clock;

    pm_loader #(.ADDR_W(8), .DATA_W(8), .HOLD_AT_RESET(1'b1)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_ready (s_ready),
        .pm_we   (pm_we),
        .pm_addr (pm_addr),
        .pm_wdata(pm_wdata),
        .cpu_hold(cpu_hold),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    int         checks   = 0;
    int         failures = 0;
    int         wcnt     = 0;
    int         dcnt     = 0;
    int         hits [256];
    logic [7:0] mem  [256];
    logic [7:0] first_addr, last_addr;

    // Write-port monitor: records what lands in memory.
    always @(negedge clock) begin
        if (pm_we === 1'b1) begin
            wcnt = wcnt + 1;
            hits[pm_addr] = hits[pm_addr] + 1;
            mem[pm_addr]  = pm_wdata;
            if (wcnt == 1) first_addr = pm_addr;
            last_addr = pm_addr;
        end
        if (done === 1'b1) dcnt = dcnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        s_valid = 1'b1;
        s_data  = b;
        step();
    endtask

    task automatic clear_mon();
        wcnt = 0;
        dcnt = 0;
        for (int i = 0; i < 256; i++) hits[i] = 0;
    endtask

    task automatic begin_session();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Called right after the final data byte's edge.
    task automatic close_frame(input logic [7:0] sum_byte);
`ifdef PM_LOADER_CHECKSUM_EN
        send(sum_byte);
`endif
        chk("done_pulse", done, 1);
        chk("err_clear", err, 0);
        chk("hold_at_done", cpu_hold, 1);
        s_valid = 1'b0;
        step();
        chk("done_drop", done, 0);
        chk("hold_release", cpu_hold, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        int bad;
        reset_n = 1'b0;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        clear_mon();
        step();
        step();
        chk("reset_vals", {s_ready, pm_we, pm_addr, pm_wdata, cpu_hold, busy, done, err},
            {1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0});
        reset_n = 1'b1;
        step();
        chk("idle_no_start", busy, 0);

        // Basic load: [0x10]=4F, [0x11]=B6, [0x12]=A6
        clear_mon();
        begin_session();
        chk("basic_busy_ready", {busy, s_ready, cpu_hold}, 3'b111);
        send(8'h10);
        send(8'h02);
        chk("basic_no_we_yet", pm_we, 0);
        send(8'h4F);
        chk("basic_w0", {pm_we, pm_addr, pm_wdata}, {1'b1, 8'h10, 8'h4F});
        send(8'hB6);
        chk("basic_w1", {pm_we, pm_addr, pm_wdata}, {1'b1, 8'h11, 8'hB6});
        chk("basic_no_early_done", done, 0);
        send(8'hA6);
        chk("basic_w2", {pm_we, pm_addr, pm_wdata}, {1'b1, 8'h12, 8'hA6});
        close_frame(8'h43);
        chk("basic_wcnt", wcnt, 3);
        chk("basic_dcnt", dcnt, 1);

        // Byte presented with start is not consumed; it becomes ADDR next cycle
        clear_mon();
        start   = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'h55;
        step();
        start = 1'b0;
        chk("sb_in_get_addr", {busy, s_ready, pm_we}, 3'b110);
        send(8'h55);
        send(8'h00);
        send(8'h77);
        chk("sb_write", {pm_we, pm_addr, pm_wdata}, {1'b1, 8'h55, 8'h77});
        close_frame(8'h34);

        // Wrap + maximum length: FE, FF, 00..FD
        clear_mon();
        begin_session();
        send(8'hFE);
        send(8'hFF);
        for (int i = 0; i < 256; i++) send(8'(i));
        close_frame(8'h83);
        chk("wrap_wcnt", wcnt, 256);
        chk("wrap_first", first_addr, 8'hFE);
        chk("wrap_last", last_addr, 8'hFD);
        chk("wrap_memFE", mem[8'hFE], 8'h00);
        chk("wrap_mem00", mem[8'h00], 8'h02);
        chk("wrap_memFD", mem[8'hFD], 8'hFF);
        bad = 0;
        for (int i = 0; i < 256; i++) if (hits[i] != 1) bad++;
        chk("wrap_once_each", bad, 0);

        // Backpressure gaps with stray start pulses
        clear_mon();
        begin_session();
        send(8'h40);
        send(8'h03);
        send(8'hAA);
        chk("bp_w0", {pm_we, pm_addr, pm_wdata}, {1'b1, 8'h40, 8'hAA});
        s_valid = 1'b0;
        start   = 1'b1;
        step();
        chk("bp_gap0", {pm_we, busy, cpu_hold}, 3'b011);
        start = 1'b0;
        send(8'hBB);
        chk("bp_w1", {pm_we, pm_addr, pm_wdata}, {1'b1, 8'h41, 8'hBB});
        s_valid = 1'b0;
        start   = 1'b1;
        step();
        start = 1'b0;
        chk("bp_gap1", pm_we, 0);
        send(8'hCC);
        chk("bp_w2", {pm_we, pm_addr, pm_wdata}, {1'b1, 8'h42, 8'hCC});
        send(8'hDD);
        chk("bp_w3", {pm_we, pm_addr, pm_wdata}, {1'b1, 8'h43, 8'hDD});
        close_frame(8'hAF);
        chk("bp_wcnt", wcnt, 4);

        // Reset in the middle of GET_DATA
        clear_mon();
        begin_session();
        send(8'h80);
        send(8'h05);
        send(8'h11);
        send(8'h22);
        chk("rst_pre_w", {pm_we, pm_addr, pm_wdata}, {1'b1, 8'h81, 8'h22});
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_async_vals", {s_ready, pm_we, pm_addr, pm_wdata, cpu_hold, busy, done, err},
            {1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0});
        chk("rst_kept_mem", mem[8'h80], 8'h11);
        step();
        #2;
        reset_n = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'h99;
        step();
        step();
        step();
        chk("rst_no_restart", {busy, s_ready, pm_we, cpu_hold}, 4'b0001);
        s_valid = 1'b0;

`ifdef PM_LOADER_CHECKSUM_EN
        // Good checksum: 20+00+BF+21 = 0x100
        begin_session();
        send(8'h20);
        send(8'h00);
        send(8'hBF);
        chk("ck_w", {pm_we, pm_addr, pm_wdata, done}, {1'b1, 8'h20, 8'hBF, 1'b0});
        send(8'h21);
        chk("ck_ok_done_err", {done, err}, 2'b10);
        s_valid = 1'b0;
        step();
        chk("ck_ok_release", cpu_hold, 0);
        // Bad checksum
        begin_session();
        send(8'h20);
        send(8'h00);
        send(8'hBF);
        send(8'h22);
        chk("ck_bad_done_err", {done, err}, 2'b11);
        s_valid = 1'b0;
        step();
        chk("ck_bad_hold", {cpu_hold, err, busy}, 3'b110);
        begin_session();
        chk("ck_start_clears", {err, busy}, 2'b01);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pm_loader.md
Name: pm_loader

Overview:
- Writer-side companion to the MPU341 program memory. It accepts a byte stream over a valid/ready handshake and fills a writable 256x8 program memory through its write port.
- It holds the CPU in reset for the whole load and releases it when the load completes.
- It sits between the host/bench byte source and the program-memory RAM write port. The CPU keeps the registered read port (1-cycle latency).

Parameters:
- ADDR_W, 8, program memory address width.
- DATA_W, 8, program memory word width; stream byte width.
- HOLD_AT_RESET, 1, reset value of cpu_hold (1 = CPU held in reset until the first load completes).

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a load session.
- s_valid  in  1  stream byte valid.
- s_data  in  DATA_W  stream byte.
- s_ready  out  1  loader accepts the byte; a transfer occurs on s_valid && s_ready.
- pm_we  out  1  program memory write enable, registered.
- pm_addr  out  ADDR_W  write address, registered.
- pm_wdata  out  DATA_W  write data, registered.
- cpu_hold  out  1  holds the CPU in reset while high.
- busy  out  1  a session is in progress (state != IDLE).
- done  out  1  one-cycle pulse at the end of a session.
- err  out  1  sticky error flag; cleared by an accepted start.

Behaviour:
- Reset values: s_ready=0, pm_we=0, pm_addr=0, pm_wdata=0, cpu_hold=HOLD_AT_RESET, busy=0, done=0, err=0, state=IDLE.
- Reset mid-session aborts immediately. Words already written remain in memory; nothing is rolled back.
- Session frame is: ADDR byte, LEN byte (number of data bytes minus 1, so 1..256 bytes), then LEN+1 data bytes.
- FSM states: IDLE, GET_ADDR, GET_LEN, GET_DATA, [GET_SUM], FINISH.
  - IDLE: s_ready=0. When start=1: cpu_hold<=1, err<=0, go to GET_ADDR. A start outside IDLE is ignored. A byte presented together with start is not consumed.
  - GET_ADDR: s_ready=1. On transfer: addr<=s_data, go to GET_LEN.
  - GET_LEN: s_ready=1. On transfer: cnt<=s_data, go to GET_DATA.
  - GET_DATA: s_ready=1. On transfer at cycle k: at cycle k+1, pm_we=1, pm_addr=addr, pm_wdata=byte; addr<=addr+1 (mod 256, so 0xFF wraps to 0x00); cnt<=cnt-1. On the transfer with cnt==0, go to FINISH (or GET_SUM with the optional feature).
  - Throughput is one byte per cycle. s_valid gaps insert idle cycles with pm_we=0. pm_we is never high without a transfer in the previous cycle.
  - FINISH: done=1 for exactly one cycle. This coincides with the final pm_we when there is no GET_SUM. Then go to IDLE. cpu_hold<=0 in the cycle after done unless err=1, in which case cpu_hold stays 1.
- A frame of 256 bytes starting at any address writes every location exactly once, including the wrap.
- s_ready depends only on state, with no combinational path from s_valid.

Optional Feature:
- Macro: PM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last data byte, state GET_SUM accepts one extra byte.
  - The 8-bit sum, mod 256, of ADDR + LEN + all data bytes + checksum byte must equal 0x00.
  - On mismatch, err<=1; done still pulses; cpu_hold stays 1.
  - Written data is not reverted.
- Undefined: there is no GET_SUM state, err is tied to 0, and the frame ends after the data bytes.

Decomposition:
- Shared package pm_loader_pkg holds:
  - the state enum typedef pm_ld_state_t;
  - constants PM_DEPTH=256 and PM_SUM_OK=8'h00.
- No sub-module. The FSM, address/count counters and checksum accumulator stay flat in one module, about 150-250 lines.

Test Plan:
- Reset: assert reset_n=0 mid-GET_DATA -> all outputs at their reset values asynchronously; cpu_hold=1; the session restarts only on a new start.
- Basic load: start, then bytes 0x10, 0x02, 0x4F, 0xB6, 0xA6 back-to-back -> pm_we on 3 consecutive cycles writing [0x10]=4F, [0x11]=B6, [0x12]=A6; done pulses once; cpu_hold falls on the next cycle.
- Wrap and max length: ADDR=0xFE, LEN=0xFF, 256 incrementing bytes -> writes run 0xFE, 0xFF, 0x00 ... 0xFD; exactly 256 pm_we pulses.
- Backpressure gaps and stray start: s_valid toggling 1/0 plus start pulses during GET_DATA -> pm_we only after accepted bytes; start ignored; address sequence unbroken.
- Checksum (macro on): frame 0x20, 0x00, 0xBF with checksum 0x21 -> err=0, cpu_hold released. Same frame with checksum 0x22 -> err=1, done pulses, cpu_hold stays 1. A following start clears err.
- Byte with start in IDLE: s_valid=1 and s_data=0x55 together with start -> 0x55 not consumed; it is taken as ADDR on the next cycle.
